// File: rtl/bin_to_bcd_seq_if.sv
// Conversion request/result bundle between a binary source and bin_to_bcd_seq.
// Handshake: the source raises start with bin valid only while busy=0; the converter
// accepts on that edge, holds busy through the conversion, and pulses done for one
// cycle with bcd/ovf already valid. Requests made while busy=1 are dropped, not queued.
interface bin_to_bcd_seq_if #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [IN_W-1:0]       bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  modport master (output start, bin, input bcd, busy, done, ovf);
  modport slave  (input start, bin, output bcd, busy, done, ovf);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment driver.
// bcd/ovf change only when a conversion completes, so the display never shows partial digits.
module bin_to_bcd_seq #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_bcd_seq_if.slave     bus,
  output logic [1:0]          state_dbg
);

  localparam int          BW     = 4 * DIGITS;
  localparam int          CNT_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [31:0] MAXVAL = 32'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state;
  logic [BW-1:0]     scratch;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic [IN_W-1:0]   bin_r;
  logic [CNT_W-1:0]  cnt;
  logic              over;

  assign state_dbg = state;

  // Add-3 correction on every nibble in parallel, then the combined shift;
  // the top scratch bit falls off, which only matters for over-range inputs.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    shifted = {adj[BW-2:0], bin_r[IN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scratch  <= '0;
      bin_r    <= '0;
      cnt      <= '0;
      over     <= 1'b0;
      bus.bcd  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          if (bus.start) begin
            bin_r    <= bus.bin;
            scratch  <= '0;
            cnt      <= '0;
            over     <= (32'(bus.bin) > MAXVAL);
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          bin_r   <= {bin_r[IN_W-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // Result registers are written on the edge entering LOAD so that
            // done, bcd and ovf are all valid together during the LOAD cycle.
            bus.bcd  <= over ? {DIGITS{4'h9}} : shifted;
            bus.ovf  <= over;
            bus.done <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq with a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;
  localparam int BW     = 4 * DIGITS;
  localparam int MAXV   = 10 ** DIGITS - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int idle_viol = 0;
  logic [BW:0] exp_q[$];

  // clock / reset support
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (state_dbg == 2'd0 && (bus.busy || bus.done)) idle_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: {ovf, packed BCD} from plain decimal digit extraction
  function automatic logic [BW:0] ref_conv(input int v);
    logic [BW-1:0] r;
    int x;
    if (v > MAXV) return {1'b1, {DIGITS{4'h9}}};
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  // driver: one conversion after 'gap' idle cycles; returns accept cycle
  task automatic do_conv(input int v, input int gap, output int acc);
    logic [BW-1:0] prev_bcd;
    int n;
    bit stable;
    @(posedge clk); #1;
    repeat (gap) begin @(posedge clk); #1; end
    n = 0;
    while (bus.busy && n < 50) begin @(posedge clk); #1; n++; end
    check("idle_before_start", {31'd0, bus.busy}, 32'd0);
    prev_bcd = bus.bcd;
    exp_q.push_back(ref_conv(v));
    bus.start = 1'b1;
    bus.bin   = IN_W'(v);
    @(posedge clk); #1;
    acc       = cyc;
    bus.start = 1'b0;
    bus.bin   = IN_W'($urandom);
    n = 0;
    stable = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (bus.bcd !== prev_bcd || !bus.busy) stable = 1'b0;
    end
    check("latency", n, IN_W + 1);
    check("hold_while_busy", {31'd0, stable}, 32'd1);
    check("result", {15'd0, bus.ovf, bus.bcd}, {15'd0, exp_q.pop_front()});
  endtask

  initial begin
    int a0, a1, d0, v;
    bit any;
    bus.start = 1'b0;
    bus.bin   = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.bcd !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) any = 1'b1;
    end
    check("reset_idle", {31'd0, any}, 32'd0);

    do_conv(1234, 2, a0);

    // back-to-back: one conversion per IN_W+2 cycles
    do_conv(0, 0, a0);
    do_conv(9, 0, a1);    check("b2b_period", a1 - a0, IN_W + 2); a0 = a1;
    do_conv(10, 0, a1);   check("b2b_period", a1 - a0, IN_W + 2); a0 = a1;
    do_conv(9999, 0, a1); check("b2b_period", a1 - a0, IN_W + 2);

    do_conv(10000, 0, a0);
    do_conv(16383, 0, a0);
    do_conv(42, 0, a0);

    // starts during busy cycle 3 and the LOAD cycle must be ignored
    @(posedge clk); #1;
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.bin   = IN_W'(5678);
    @(posedge clk); #1;
    for (int k = 1; k <= IN_W + 1; k++) begin
      bus.start = (k == 3 || k == IN_W + 1);
      bus.bin   = IN_W'(1111);
      @(negedge clk);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    check("single_done", done_cnt - d0, 1);
    check("ignored_start_bcd", {16'd0, bus.bcd}, 32'h5678);
    check("ignored_start_busy", {31'd0, bus.busy}, 32'd0);

    // reset mid-conversion drops it and clears results
    do_conv(777, 0, a0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bin   = IN_W'(4321);
    @(posedge clk); #1;
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_bcd", {16'd0, bus.bcd}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    repeat (20) begin @(posedge clk); #1; end
    check("rst_no_done", done_cnt - d0, 0);
    do_conv(8765, 0, a0);

    // randomized values, biased toward the overflow boundary
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) v = $urandom_range(MAXV - 2, MAXV + 2);
      else            v = $urandom_range(0, (1 << IN_W) - 1);
      do_conv(v, $urandom_range(0, 3), a0);
    end

    check("idle_pulse_free", idle_viol, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
